// File: rtl/pattern_det_param_if.sv
// rtl/pattern_det_param_if.sv - serial bit, control and result bundle for pattern_det_param
// Optional mask_in signal present when PAT_DET_MASK_EN is defined.
interface pattern_det_param_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             en;
   logic             x;
   logic             load;
   logic [PAT_W-1:0] pat_in;
   logic             overlap;
`ifdef PAT_DET_MASK_EN
   logic [PAT_W-1:0] mask_in;
`endif
   logic             y;
   logic [CNT_W-1:0] match_cnt;

`ifdef PAT_DET_MASK_EN
   modport master (output en, x, load, pat_in, overlap, mask_in, input y, match_cnt);
   modport slave  (input en, x, load, pat_in, overlap, mask_in, output y, match_cnt);
`else
   modport master (output en, x, load, pat_in, overlap, input y, match_cnt);
   modport slave  (input en, x, load, pat_in, overlap, output y, match_cnt);
`endif
endinterface

// File: rtl/pattern_det_param.sv
// rtl/pattern_det_param.sv - parametrised serial pattern detector with loadable pattern and match counter
// Define PAT_DET_MASK_EN to add a loadable don't-care mask.
module pattern_det_param #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
   parameter int               CNT_W   = 8
) (
   input logic               clk,
   input logic               rst,
   pattern_det_param_if.slave bus
);
   localparam int             FW   = $clog2(PAT_W + 1);
   localparam logic [FW-1:0]  FULL = FW'(PAT_W);

   logic [PAT_W-1:0] pat;
   logic [PAT_W-1:0] hist;
   logic [FW-1:0]    fill;
   logic             y_q;
   logic [CNT_W-1:0] cnt_q;
`ifdef PAT_DET_MASK_EN
   logic [PAT_W-1:0] mask;
`endif

   logic [PAT_W-1:0] nh;
   logic [FW-1:0]    nf;
   logic             match;

   always_comb begin
      nh = {hist[PAT_W-2:0], bus.x};
      nf = (fill == FULL) ? FULL : fill + FW'(1);
`ifdef PAT_DET_MASK_EN
      match = (nf == FULL) && (((nh ^ pat) & ~mask) == '0);
`else
      match = (nf == FULL) && (nh == pat);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat   <= PATTERN;
         hist  <= '0;
         fill  <= '0;
         y_q   <= 1'b0;
         cnt_q <= '0;
`ifdef PAT_DET_MASK_EN
         mask  <= '0;
`endif
      end else if (bus.load) begin
         // the x sample of a load cycle is dropped even when en is high
         pat  <= bus.pat_in;
         hist <= '0;
         fill <= '0;
         y_q  <= 1'b0;
`ifdef PAT_DET_MASK_EN
         mask <= bus.mask_in;
`endif
      end else if (bus.en) begin
         hist <= nh;
         y_q  <= match;
         // non-overlapping mode restarts the fill so matched bits cannot be reused
         fill <= (match && !bus.overlap) ? '0 : nf;
         if (match && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         y_q <= 1'b0;
      end
   end

   assign bus.y         = y_q;
   assign bus.match_cnt = cnt_q;
endmodule

// File: doc/pattern_det_param.md
Name: pattern_det_param

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed 4-bit pattern detectors. It takes one serial bit per enabled clock and pulses a registered match flag when the last PAT_W received bits equal a runtime-loadable pattern. Overlapping or non-overlapping detection is selectable at run time, and a saturating match counter is provided. It sits on serial data/control streams wherever a framing or sync word must be spotted.

Parameters:
PAT_W, 4, pattern length in bits; must be >= 2
PATTERN, 4'b1101, pattern value after reset, PAT_W bits wide
CNT_W, 8, match counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
en  in  1  sample x this cycle when 1
x  in  1  serial data bit
load  in  1  load pat_in as the new pattern; clears history
pat_in  in  PAT_W  new pattern value
overlap  in  1  1 = overlapping detection, 0 = non-overlapping
y  out  1  registered one-cycle match pulse
match_cnt  out  CNT_W  saturating count of matches

Behaviour:
- State: pat reg (PAT_W), hist shift reg (PAT_W), fill counter (0..PAT_W), y reg, match_cnt reg.
- Reset (rst=1 at edge): pat=PATTERN, hist=0, fill=0, y=0, match_cnt=0. rst has priority over load and en.
- Bit order is MSB-first. The first bit of a sequence is compared against pat[PAT_W-1]. The most recent bit is compared against pat[0].
- On an edge with en=1 and load=0:
  - nh = {hist[PAT_W-2:0], x}; nf = min(fill+1, PAT_W).
  - match = (nf == PAT_W) && (nh == pat).
  - hist <= nh. y <= match.
  - If match and overlap=0: fill <= 0, so the bits that formed the match cannot start a new one. Otherwise fill <= nf.
  - If match: match_cnt <= match_cnt+1, saturating at 2^CNT_W-1 with no wrap.
- On an edge with en=0 and load=0: hist, fill and pat hold; y <= 0; match_cnt holds.
- On an edge with load=1: pat <= pat_in, hist <= 0, fill <= 0, y <= 0, match_cnt holds. The x sample in that cycle is discarded even if en=1.
- Latency: y rises on the same edge that samples the final pattern bit, is visible for the following cycle, and lasts exactly one cycle per match.
- No match is possible until PAT_W bits have been sampled since reset, load, or a non-overlapping match. A partial prefix before load or rst never contributes.
- overlap may change on any cycle. It takes effect at the edge where it is sampled and does not retroactively alter fill.
- With overlap=1 and a self-overlapping pattern (e.g. 1111), consecutive enabled bits give back-to-back y pulses.

Optional Feature:
- Macro: PAT_DET_MASK_EN.
- When defined:
  - Adds input mask_in (PAT_W), loaded into a mask reg on load. mask reset value is all zeros.
  - A mask bit of 1 makes that pattern position don't-care: match requires ((nh ^ pat) & ~mask) == 0, still gated by nf == PAT_W.
- When undefined: no mask_in port, no mask reg, exact compare as above.

Test Plan:
- Reset defaults, overlap=1, en=1, x stream 1,1,0,1,1,0,1 -> y pulses after the 4th and 7th bits; match_cnt=2.
- Same stream with overlap=0 -> y pulses only after the 4th bit; match_cnt=1.
- overlap=1, en=1, x = 1,1,0; then en=0 for 3 cycles with x=1; then en=1, x=1 -> y=0 throughout the stall, single y pulse after the final 1; match_cnt=1.
- Stream 0,1,1 then load=1 with pat_in=4'b0110 (en=1, x=0 ignored); then x = 0,1,1,0 -> y=0 until the 4th post-load bit, then one pulse; match_cnt increments by 1.
- CNT_W=2, overlap=1, pattern 4'b1111, eight 1s -> y high on bits 4-8 (5 pulses); match_cnt saturates at 3.
- Stream 1,1,0 then rst=1 for one cycle (x=1, load=1 ignored); then x=1 -> no y; match_cnt=0; pat=4'b1101.
- (PAT_DET_MASK_EN) load pat_in=4'b1001, mask_in=4'b0110; streams 1,0,0,1 and 1,1,1,1 -> each yields one y pulse.
